branch_compare_unit: RTL and testbench

Parametrised, pipelined branch-condition comparator for the processor's branch-resolution path. It supersedes the single 32-bit equality check. It evaluates six signed/unsigned relations, selected per request by a funct3-style mode. Results are registered over two stages with stall and flush control, and the block keeps a saturating count of taken branches for performance monitoring.

---
 rtl/branch_compare_unit.sv | 96 +++++++++
 tb/tb_branch_compare_unit.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_compare_unit.sv
// Two-stage pipelined branch-condition comparator: evaluates six signed/unsigned
// relations selected by a funct3-style mode and keeps a saturating taken-branch count.
module branch_compare_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             stall,
  input  logic             flush,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             out_valid,
  output logic             taken,
  output logic             equal,
  output logic             less,
  output logic             less_u,
  output logic             illegal_mode,
  output logic [CNT_W-1:0] taken_count
);

  localparam logic [2:0] MODE_EQ  = 3'b000;
  localparam logic [2:0] MODE_NE  = 3'b001;
  localparam logic [2:0] MODE_LT  = 3'b100;
  localparam logic [2:0] MODE_GE  = 3'b101;
  localparam logic [2:0] MODE_LTU = 3'b110;
  localparam logic [2:0] MODE_GEU = 3'b111;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid;
  logic [2:0]       s1_mode;
  logic [WIDTH-1:0] s1_opa;
  logic [WIDTH-1:0] s1_opb;

  logic s1_eq;
  logic s1_lt;
  logic s1_ltu;
  logic s1_taken;
  logic s1_illegal;

  // Relation evaluation on the stage-1 contents; feeds the stage-2 registers.
  always_comb begin
    s1_eq      = (s1_opa == s1_opb);
    s1_lt      = ($signed(s1_opa) < $signed(s1_opb));
    s1_ltu     = (s1_opa < s1_opb);
    s1_taken   = 1'b0;
    s1_illegal = 1'b0;
    case (s1_mode)
      MODE_EQ:  s1_taken = s1_eq;
      MODE_NE:  s1_taken = ~s1_eq;
      MODE_LT:  s1_taken = s1_lt;
      MODE_GE:  s1_taken = ~s1_lt;
      MODE_LTU: s1_taken = s1_ltu;
      MODE_GEU: s1_taken = ~s1_ltu;
      default:  s1_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      s1_mode      <= '0;
      s1_opa       <= '0;
      s1_opb       <= '0;
      out_valid    <= 1'b0;
      taken        <= 1'b0;
      equal        <= 1'b0;
      less         <= 1'b0;
      less_u       <= 1'b0;
      illegal_mode <= 1'b0;
      taken_count  <= '0;
    end else if (flush) begin
      // Flush wins over stall; only the valid bits need clearing.
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      s1_valid     <= in_valid;
      s1_mode      <= mode;
      s1_opa       <= opa;
      s1_opb       <= opb;
      out_valid    <= s1_valid;
      taken        <= s1_taken;
      equal        <= s1_eq;
      less         <= s1_lt;
      less_u       <= s1_ltu;
      illegal_mode <= s1_illegal;
      if (s1_valid && s1_taken && (taken_count != CNT_MAX)) begin
        taken_count <= taken_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_compare_unit.sv
// Randomized self-checking bench for branch_compare_unit: a transaction-level
// reference model predicts results; a second instance with CNT_W=2 checks saturation.
module tb_branch_compare_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  mode = 3'b000;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;

  logic        out_valid, taken, equal, less, less_u, illegal_mode;
  logic [15:0] taken_count;
  logic        sat_out_valid, sat_taken, sat_equal, sat_less, sat_less_u, sat_illegal_mode;
  logic [1:0]  sat_taken_count;

  int checks = 0;
  int failures = 0;

  // Reference model state: one request waiting in stage 1, one result on the outputs.
  logic        m1Valid = 1'b0;
  logic [2:0]  m1Mode = '0;
  logic [31:0] m1A = '0;
  logic [31:0] m1B = '0;
  logic        m2Valid = 1'b0;
  logic        m2Taken = 1'b0;
  logic        m2Eq = 1'b0;
  logic        m2Lt = 1'b0;
  logic        m2Ltu = 1'b0;
  logic        m2Ill = 1'b0;
  int          cnt = 0;
  int          cntSat = 0;

  always #5 clk = ~clk;

  branch_compare_unit #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .mode(mode), .opa(opa), .opb(opb),
    .out_valid(out_valid), .taken(taken), .equal(equal), .less(less),
    .less_u(less_u), .illegal_mode(illegal_mode), .taken_count(taken_count)
  );

  branch_compare_unit #(.WIDTH(32), .CNT_W(2)) dutSat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .stall(stall), .flush(flush),
    .mode(mode), .opa(opa), .opb(opb),
    .out_valid(sat_out_valid), .taken(sat_taken), .equal(sat_equal), .less(sat_less),
    .less_u(sat_less_u), .illegal_mode(sat_illegal_mode), .taken_count(sat_taken_count)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h at time %0t", tag, obs, exp, $time);
    end
  endtask

  // Relations computed from integer values rather than bit tricks.
  task automatic evalRel(input logic [31:0] a, input logic [31:0] b, input logic [2:0] md,
                         output logic eq, output logic lt, output logic ltu,
                         output logic tk, output logic ill);
    longint sa, sb, ua, ub;
    ua = longint'(a);
    ub = longint'(b);
    sa = a[31] ? ua - 64'sh1_0000_0000 : ua;
    sb = b[31] ? ub - 64'sh1_0000_0000 : ub;
    eq  = (ua == ub);
    lt  = (sa < sb);
    ltu = (ua < ub);
    ill = 1'b0;
    tk  = 1'b0;
    case (md)
      3'd0: tk = eq;
      3'd1: tk = !eq;
      3'd4: tk = lt;
      3'd5: tk = !lt;
      3'd6: tk = ltu;
      3'd7: tk = !ltu;
      default: ill = 1'b1;
    endcase
  endtask

  task automatic modelEdge();
    if (flush) begin
      m1Valid = 1'b0;
      m2Valid = 1'b0;
    end else if (!stall) begin
      evalRel(m1A, m1B, m1Mode, m2Eq, m2Lt, m2Ltu, m2Taken, m2Ill);
      m2Valid = m1Valid;
      if (m1Valid && m2Taken) begin
        if (cnt < 65535) cnt++;
        if (cntSat < 3) cntSat++;
      end
      m1Valid = in_valid;
      m1Mode  = mode;
      m1A     = opa;
      m1B     = opb;
    end
  endtask

  task automatic checkAll();
    checkOutput("out_valid", 32'(out_valid), 32'(m2Valid));
    checkOutput("taken_count", 32'(taken_count), cnt);
    checkOutput("sat_out_valid", 32'(sat_out_valid), 32'(m2Valid));
    checkOutput("sat_taken_count", 32'(sat_taken_count), cntSat);
    if (m2Valid) begin
      checkOutput("taken", 32'(taken), 32'(m2Taken));
      checkOutput("equal", 32'(equal), 32'(m2Eq));
      checkOutput("less", 32'(less), 32'(m2Lt));
      checkOutput("less_u", 32'(less_u), 32'(m2Ltu));
      checkOutput("illegal_mode", 32'(illegal_mode), 32'(m2Ill));
      checkOutput("sat_taken", 32'(sat_taken), 32'(m2Taken));
    end
  endtask

  // Drive one cycle of inputs at the falling edge, step the model at the rising edge, check at the next falling edge.
  task automatic applyStimulus(input logic v, input logic st, input logic fl, input logic [2:0] md,
                               input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    stall    = st;
    flush    = fl;
    mode     = md;
    opa      = a;
    opb      = b;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkAll();
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_out_valid"}, 32'(out_valid), 0);
    checkOutput({tag, "_flags"}, 32'({taken, equal, less, less_u, illegal_mode}), 0);
    checkOutput({tag, "_count"}, 32'(taken_count), 0);
    checkOutput({tag, "_sat_out_valid"}, 32'(sat_out_valid), 0);
    checkOutput({tag, "_sat_count"}, 32'(sat_taken_count), 0);
  endtask

  task automatic clearModel();
    m1Valid = 1'b0;
    m2Valid = 1'b0;
    m1Mode  = '0;
    m1A     = '0;
    m1B     = '0;
    cnt     = 0;
    cntSat  = 0;
  endtask

  function automatic logic [31:0] pickOp();
    logic [31:0] edgeVals [6];
    edgeVals = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0001};
    if ($urandom_range(0, 2) == 0) return edgeVals[$urandom_range(0, 5)];
    return $urandom();
  endfunction

  task automatic randomCycles(input int n);
    logic [31:0] a, b;
    for (int i = 0; i < n; i++) begin
      a = pickOp();
      b = ($urandom_range(0, 3) == 0) ? a : pickOp();
      applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 15) == 0), 3'($urandom_range(0, 7)), a, b);
    end
  endtask

  initial begin
    int savedCnt;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkAllZero("reset");
    rst = 1'b0;

    // EQ equal operands, single request then idle
    applyStimulus(1, 0, 0, 3'b000, 32'h0000_00A5, 32'h0000_00A5);
    applyStimulus(0, 0, 0, 3'b000, 0, 0);
    checkOutput("eq_first_count", 32'(taken_count), 1);
    applyStimulus(0, 0, 0, 3'b000, 0, 0);

    // Signed vs unsigned back-to-back
    applyStimulus(1, 0, 0, 3'b100, 32'hFFFF_FFFF, 32'h1);
    applyStimulus(1, 0, 0, 3'b110, 32'hFFFF_FFFF, 32'h1);
    applyStimulus(1, 0, 0, 3'b101, 32'hFFFF_FFFF, 32'h1);
    applyStimulus(1, 0, 0, 3'b111, 32'hFFFF_FFFF, 32'h1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 3'b000, 0, 0);
    checkOutput("signed_unsigned_count", 32'(taken_count), 3);

    // Stall holds an in-flight NE result
    applyStimulus(1, 0, 0, 3'b001, 32'd5, 32'd6);
    for (int i = 0; i < 3; i++) applyStimulus(1, 1, 0, 3'b000, 32'd9, 32'd9);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 3'b000, 0, 0);

    // Flush with stall kills in-flight and presented requests
    savedCnt = cnt;
    applyStimulus(1, 0, 0, 3'b000, 32'd7, 32'd7);
    applyStimulus(1, 1, 1, 3'b000, 32'd7, 32'd7);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 3'b000, 0, 0);
    checkOutput("flush_count_unchanged", 32'(taken_count), savedCnt);

    // Illegal mode with equal operands
    applyStimulus(1, 0, 0, 3'b010, 32'h1234, 32'h1234);
    applyStimulus(0, 0, 0, 3'b000, 0, 0);
    checkOutput("illegal_flag", 32'(illegal_mode), 1);
    applyStimulus(0, 0, 0, 3'b000, 0, 0);

    // Five taken EQ requests drive the narrow counter into saturation
    for (int i = 0; i < 5; i++) applyStimulus(1, 0, 0, 3'b000, 32'(i), 32'(i));
    for (int i = 0; i < 2; i++) applyStimulus(0, 0, 0, 3'b000, 0, 0);
    checkOutput("sat_count_held", 32'(sat_taken_count), 3);

    randomCycles(400);

    // Asynchronous reset mid-stream, observed before any clock edge
    applyStimulus(1, 0, 0, 3'b000, 32'd1, 32'd1);
    applyStimulus(1, 0, 0, 3'b001, 32'd1, 32'd2);
    #2 rst = 1'b1;
    #1 checkAllZero("async_reset");
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clearModel();
    rst = 1'b0;
    checkAllZero("after_reset");

    randomCycles(200);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, 3'b000, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $fatal(1, "[TB] timeout");
  end

endmodule
